// File: rtl/axi4_write_sequence.sv
// AXI4 write initiator for the LPDDR4 memory-test path.
// Writes an incrementing lane pattern over an address range, one INCR burst at a time.
module axi4_write_sequence #(
    parameter int          pAxi4BusWidth = 512,
    parameter int          pDataBitWidth = 16,
    parameter int          pDdrBurstSize = 16,
    parameter logic [32:0] pStartAdrs    = 33'h0_0000_0000,
    parameter logic [32:0] pStopAdrs     = 33'h0_0000_3C00
) (
    input  logic                         iCLK,
    input  logic                         iRST,
    input  logic                         iStart,
    output logic [32:0]                  o_awaddr,
    output logic [7:0]                   o_awlen,
    output logic [2:0]                   o_awsize,
    output logic [1:0]                   o_awburst,
    output logic [5:0]                   o_awid,
    output logic                         o_awlock,
    output logic                         o_awqos,
    output logic                         o_awapcmd,
    output logic                         o_awvalid,
    input  logic                         i_awready,
    output logic [pAxi4BusWidth-1:0]     o_wdata,
    output logic [pAxi4BusWidth/8-1:0]   o_wstrb,
    output logic                         o_wlast,
    output logic                         o_wvalid,
    input  logic                         i_wready,
    input  logic [5:0]                   i_bid,
    input  logic [1:0]                   i_bresp,
    input  logic                         i_bvalid,
    output logic                         o_bready,
    output logic                         o_wdone,
    output logic                         o_werr,
    output logic                         o_busy
);

    localparam int          Lanes      = pAxi4BusWidth / pDataBitWidth;
    localparam logic [32:0] BurstBytes = 33'(pDdrBurstSize * (pAxi4BusWidth / 8));
    localparam logic [7:0]  LastBeat   = 8'(pDdrBurstSize - 1);
    localparam logic [2:0]  AwSize     = 3'($clog2(pAxi4BusWidth / 8));

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [32:0]                addr_q, addr_d;
    logic [7:0]                 beat_q, beat_d;
    logic [31:0]                g_q, g_d;
    logic [pAxi4BusWidth-1:0]   wdata_q, wdata_d;
    logic                       awvalid_q, awvalid_d;
    logic                       wvalid_q, wvalid_d;
    logic                       wlast_q, wlast_d;
    logic                       bready_q, bready_d;
    logic                       wdone_q, wdone_d;
    logic                       werr_q, werr_d;
    logic                       busy_q, busy_d;

    // Response id carries no information for a single-outstanding initiator.
    logic unused_bid;
    assign unused_bid = ^i_bid;

    function automatic logic [pAxi4BusWidth-1:0] pattern(input logic [31:0] g);
        logic [pAxi4BusWidth-1:0] v;
        v = '0;
        for (int x = 0; x < Lanes; x++) begin
            v[x*pDataBitWidth +: pDataBitWidth] =
                pDataBitWidth'(g * 32'(Lanes) + 32'(x));
        end
        return v;
    endfunction

    // Next-state and output decode for the AW -> W -> B burst loop.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        beat_d    = beat_q;
        g_d       = g_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        wlast_d   = wlast_q;
        bready_d  = bready_q;
        wdone_d   = wdone_q;
        werr_d    = werr_q;
        busy_d    = busy_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (iStart) begin
                    state_d   = S_AW;
                    awvalid_d = 1'b1;
                    busy_d    = 1'b1;
                    wdone_d   = 1'b0;
                    werr_d    = 1'b0;
                    g_d       = '0;
                    beat_d    = '0;
                    addr_d    = pStartAdrs;
                    wdata_d   = pattern(32'd0);
                end
            end
            S_AW: begin
                if (i_awready) begin
                    state_d   = S_W;
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b1;
                    wlast_d   = (beat_q == LastBeat);
                end
            end
            S_W: begin
                if (i_wready) begin
                    g_d     = g_q + 32'd1;
                    wdata_d = pattern(g_q + 32'd1);
                    if (wlast_q) begin
                        state_d  = S_B;
                        beat_d   = '0;
                        wvalid_d = 1'b0;
                        wlast_d  = 1'b0;
                        bready_d = 1'b1;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        wlast_d = ((beat_q + 8'd1) == LastBeat);
                    end
                end
            end
            S_B: begin
                if (i_bvalid) begin
                    bready_d = 1'b0;
                    if (i_bresp != 2'b00) begin
                        werr_d = 1'b1;
                    end
                    if (addr_q == pStopAdrs) begin
                        state_d = S_DONE;
                        wdone_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d   = S_AW;
                        addr_d    = addr_q + BurstBytes;
                        awvalid_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any burst in flight.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q   <= S_IDLE;
            addr_q    <= pStartAdrs;
            beat_q    <= '0;
            g_q       <= '0;
            wdata_q   <= pattern(32'd0);
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            wdone_q   <= 1'b0;
            werr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            beat_q    <= beat_d;
            g_q       <= g_d;
            wdata_q   <= wdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            wlast_q   <= wlast_d;
            bready_q  <= bready_d;
            wdone_q   <= wdone_d;
            werr_q    <= werr_d;
            busy_q    <= busy_d;
        end
    end

    assign o_awaddr  = addr_q;
    assign o_awlen   = LastBeat;
    assign o_awsize  = AwSize;
    assign o_awburst = 2'b01;
    assign o_awid    = 6'd0;
    assign o_awlock  = 1'b0;
    assign o_awqos   = 1'b0;
    assign o_awapcmd = 1'b0;
    assign o_awvalid = awvalid_q;
    assign o_wdata   = wdata_q;
    assign o_wstrb   = '1;
    assign o_wlast   = wlast_q;
    assign o_wvalid  = wvalid_q;
    assign o_bready  = bready_q;
    assign o_wdone   = wdone_q;
    assign o_werr    = werr_q;
    assign o_busy    = busy_q;

endmodule

// File: tb/tb_axi4_write_sequence.sv
// Testbench for axi4_write_sequence: table-driven passes with a scoreboard
// of expected burst addresses and beat indices, plus a mid-burst reset case.
module tb_axi4_write_sequence;

    localparam int BW = 512;
    localparam int L  = 32;
    localparam int N  = 16;
    localparam int NB = 16;

    logic            iCLK = 1'b0;
    logic            iRST = 1'b1;
    logic            iStart = 1'b0;
    logic [32:0]     o_awaddr;
    logic [7:0]      o_awlen;
    logic [2:0]      o_awsize;
    logic [1:0]      o_awburst;
    logic [5:0]      o_awid;
    logic            o_awlock, o_awqos, o_awapcmd, o_awvalid;
    logic            i_awready = 1'b1;
    logic [BW-1:0]   o_wdata;
    logic [BW/8-1:0] o_wstrb;
    logic            o_wlast, o_wvalid;
    logic            i_wready = 1'b1;
    logic [5:0]      i_bid = 6'd0;
    logic [1:0]      i_bresp = 2'b00;
    logic            i_bvalid = 1'b1;
    logic            o_bready, o_wdone, o_werr, o_busy;

    axi4_write_sequence dut (
        .iCLK(iCLK), .iRST(iRST), .iStart(iStart),
        .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
        .o_awburst(o_awburst), .o_awid(o_awid), .o_awlock(o_awlock),
        .o_awqos(o_awqos), .o_awapcmd(o_awapcmd), .o_awvalid(o_awvalid),
        .i_awready(i_awready), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
        .o_wlast(o_wlast), .o_wvalid(o_wvalid), .i_wready(i_wready),
        .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid),
        .o_bready(o_bready), .o_wdone(o_wdone), .o_werr(o_werr),
        .o_busy(o_busy)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        int         aw_delay;
        int         stall_beat;
        int         stall_len;
        int         bresp_burst;
        logic [1:0] bresp;
        int         extra_start;
        logic       exp_werr;
    } vec_t;

    vec_t tbl[5];
    vec_t cfg;

    int n_chk  = 0;
    int n_fail = 0;

    logic [32:0] aq[$];
    int          gq[$];
    bit          lq[$];
    int          aw_hs, w_hs, b_hs, aw_wait, stall_cnt;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ready/response responder and scoreboard monitor, evaluated mid-cycle.
    initial begin
        forever begin
            @(negedge iCLK);
            if (!iRST) begin
                i_bid     = 6'($urandom_range(0, 63));
                i_awready = 1'b1;
                if (o_awvalid && aw_hs == 0 && aw_wait < cfg.aw_delay) begin
                    i_awready = 1'b0;
                    aw_wait++;
                end
                i_wready = 1'b1;
                if (o_wvalid && w_hs == cfg.stall_beat &&
                    stall_cnt < cfg.stall_len) begin
                    i_wready = 1'b0;
                    stall_cnt++;
                end
                i_bvalid = 1'b1;
                i_bresp  = (b_hs == cfg.bresp_burst) ? cfg.bresp : 2'b00;
                if (o_awvalid) begin
                    chk("aw_w_overlap", {63'd0, o_wvalid}, 64'd0);
                    if (aq.size() == 0) begin
                        chk("aw_unexpected", 64'd1, 64'd0);
                    end else begin
                        chk("awaddr", {31'd0, o_awaddr}, {31'd0, aq[0]});
                        if (i_awready) begin
                            void'(aq.pop_front());
                            aw_hs++;
                        end
                    end
                end
                if (o_wvalid) begin
                    if (gq.size() == 0) begin
                        chk("w_unexpected", 64'd1, 64'd0);
                    end else begin
                        chk("lane0", {48'd0, o_wdata[15:0]},
                            {48'd0, 16'(gq[0] * L)});
                        chk("lane31", {48'd0, o_wdata[511:496]},
                            {48'd0, 16'(gq[0] * L + 31)});
                        chk("wlast", {63'd0, o_wlast}, {63'd0, lq[0]});
                        if (i_wready) begin
                            void'(gq.pop_front());
                            void'(lq.pop_front());
                            w_hs++;
                        end
                    end
                end
                if (o_bready && i_bvalid) b_hs++;
            end
        end
    end

    task automatic start_pass();
        aw_hs = 0; w_hs = 0; b_hs = 0; aw_wait = 0; stall_cnt = 0;
        aq.delete(); gq.delete(); lq.delete();
        for (int b = 0; b < NB; b++) aq.push_back(33'(b * 32'h400));
        for (int g = 0; g < NB * N; g++) begin
            gq.push_back(g);
            lq.push_back((g % N) == N - 1);
        end
        iStart = 1'b1;
        @(negedge iCLK);
        iStart = 1'b0;
        chk("start_busy", {63'd0, o_busy}, 64'd1);
        chk("start_wdone", {63'd0, o_wdone}, 64'd0);
        chk("start_werr", {63'd0, o_werr}, 64'd0);
        chk("start_awvalid", {63'd0, o_awvalid}, 64'd1);
    endtask

    task automatic finish_pass(input logic exp_werr);
        int cyc;
        cyc = 0;
        while (!o_wdone && cyc < 3000) begin
            @(negedge iCLK);
            cyc++;
            iStart = (cfg.extra_start >= 0 && w_hs == cfg.extra_start);
        end
        iStart = 1'b0;
        chk("pass_timeout", {63'd0, cyc < 3000}, 64'd1);
        chk("done_werr", {63'd0, o_werr}, {63'd0, exp_werr});
        chk("done_busy", {63'd0, o_busy}, 64'd0);
        chk("aw_count", 64'(aw_hs), 64'(NB));
        chk("w_count", 64'(w_hs), 64'(NB * N));
        chk("b_count", 64'(b_hs), 64'(NB));
        chk("sb_empty", 64'(aq.size() + gq.size()), 64'd0);
        repeat (3) @(negedge iCLK);
        chk("done_held", {63'd0, o_wdone}, 64'd1);
        chk("done_idle_aw", {63'd0, o_awvalid}, 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_awvalid"}, {63'd0, o_awvalid}, 64'd0);
        chk({tag, "_wvalid"}, {63'd0, o_wvalid}, 64'd0);
        chk({tag, "_wlast"}, {63'd0, o_wlast}, 64'd0);
        chk({tag, "_bready"}, {63'd0, o_bready}, 64'd0);
        chk({tag, "_wdone"}, {63'd0, o_wdone}, 64'd0);
        chk({tag, "_werr"}, {63'd0, o_werr}, 64'd0);
        chk({tag, "_busy"}, {63'd0, o_busy}, 64'd0);
        chk({tag, "_awaddr"}, {31'd0, o_awaddr}, 64'd0);
        chk({tag, "_lane0"}, {48'd0, o_wdata[15:0]}, 64'd0);
        chk({tag, "_lane1"}, {48'd0, o_wdata[31:16]}, 64'd1);
        chk({tag, "_lane31"}, {48'd0, o_wdata[511:496]}, 64'd31);
    endtask

    initial begin
        tbl[0] = '{aw_delay: 0,  stall_beat: -1, stall_len: 0, bresp_burst: -1,
                   bresp: 2'b00, extra_start: 40, exp_werr: 1'b0};
        tbl[1] = '{aw_delay: 0,  stall_beat: 3,  stall_len: 5, bresp_burst: -1,
                   bresp: 2'b00, extra_start: -1, exp_werr: 1'b0};
        tbl[2] = '{aw_delay: 10, stall_beat: -1, stall_len: 0, bresp_burst: -1,
                   bresp: 2'b00, extra_start: -1, exp_werr: 1'b0};
        tbl[3] = '{aw_delay: 0,  stall_beat: -1, stall_len: 0, bresp_burst: 4,
                   bresp: 2'b10, extra_start: -1, exp_werr: 1'b1};
        tbl[4] = '{aw_delay: 3,  stall_beat: 20, stall_len: 2, bresp_burst: -1,
                   bresp: 2'b00, extra_start: -1, exp_werr: 1'b0};
        cfg = tbl[1];
        cfg.stall_len = 0;
        aw_hs = 0; w_hs = 0; b_hs = 0; aw_wait = 0; stall_cnt = 0;

        iRST = 1'b1;
        repeat (3) @(negedge iCLK);
        check_idle_outputs("reset");
        chk("awlen", 64'(o_awlen), 64'd15);
        chk("awsize", 64'(o_awsize), 64'd6);
        chk("awburst", 64'(o_awburst), 64'd1);
        chk("awid_lock_qos_apcmd",
            64'({o_awid, o_awlock, o_awqos, o_awapcmd}), 64'd0);
        chk("wstrb_ones", 64'(&o_wstrb), 64'd1);
        iRST = 1'b0;
        @(negedge iCLK);
        check_idle_outputs("idle");

        for (int r = 0; r < 5; r++) begin
            cfg = tbl[r];
            start_pass();
            finish_pass(cfg.exp_werr);
        end

        cfg = tbl[1];
        cfg.stall_len = 0;
        start_pass();
        begin
            int cyc;
            cyc = 0;
            while (w_hs < 2 * N + 5 && cyc < 1000) begin
                @(negedge iCLK);
                cyc++;
            end
            chk("reach_burst2", {63'd0, cyc < 1000}, 64'd1);
        end
        chk("midburst_wvalid", {63'd0, o_wvalid}, 64'd1);
        iRST = 1'b1;
        @(negedge iCLK);
        check_idle_outputs("midrst");
        iRST = 1'b0;
        aq.delete(); gq.delete(); lq.delete();
        @(negedge iCLK);
        check_idle_outputs("postrst");
        start_pass();
        chk("restart_awaddr", {31'd0, o_awaddr}, 64'd0);
        chk("restart_lane0", {48'd0, o_wdata[15:0]}, 64'd0);
        finish_pass(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
